// File: rtl/wav_dfi_hs_pkg.sv
// Shared types and constants for the DFI handshake monitor.
// Error bit indices match the err_vec layout seen by software and benches.
package wav_dfi_hs_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACKED, REL} ch_state_e;

  localparam int N_ERR           = 10;
  localparam int ERR_TO_LP_CTRL  = 0;
  localparam int ERR_TO_LP_DATA  = 1;
  localparam int ERR_TO_PHYUPD   = 2;
  localparam int ERR_TO_CTRLUPD  = 3;
  localparam int ERR_REL_TIMEOUT = 4;
  localparam int ERR_PROTO       = 5;
  localparam int ERR_UPD_MSTR    = 6;
  localparam int ERR_INIT        = 7;
  localparam int ERR_ADDR_BUSY   = 8;
  localparam int ERR_LP_DATA_EN  = 9;

  // Address pattern treated as a non-idle command on the DFI bus.
  localparam int unsigned NONIDLE_ADDR = 1;

  function automatic logic [3:0] lowest_set(input logic [N_ERR-1:0] v);
    lowest_set = '0;
    for (int i = N_ERR - 1; i >= 0; i--)
      if (v[i]) lowest_set = 4'(i);
  endfunction

endpackage

// File: rtl/wav_dfi_hs_channel.sv
// One req/ack handshake tracker: IDLE -> WAIT -> ACKED -> REL -> IDLE.
// Violation outputs are combinational pulses for the current cycle; the top registers them.
module wav_dfi_hs_channel
  import wav_dfi_hs_pkg::*;
#(
  parameter int TIMEOUT    = 8,
  parameter int REL_LIMIT  = 8,
  parameter bit ABANDON_OK = 1'b0,
  parameter bit STRICT_REL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic timeout,
  output logic rel_timeout,
  output logic proto_err,
  output logic busy
);

  localparam int LIMIT = (TIMEOUT > REL_LIMIT) ? TIMEOUT : REL_LIMIT;
  localparam int CW    = $clog2(LIMIT + 1);

  ch_state_e     state;
  logic [CW-1:0] cnt;
  logic          req_q;
  logic          req_rise;

  assign req_rise = req & ~req_q;
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= 1'b0;
    end else begin
      req_q <= req;
      case (state)
        IDLE: if (req_rise) begin
          state <= ack ? ACKED : WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (ack)                         state <= ACKED;
          else if (!req)                   state <= IDLE;
          else if (cnt != CW'(TIMEOUT))    cnt   <= cnt + 1'b1;
        end
        ACKED: begin
          if (!req) begin
            state <= REL;
            cnt   <= '0;
          end else if (!ack) begin
            state <= IDLE;
          end
        end
        REL: begin
          if (!ack)                                         state <= IDLE;
          else if (!STRICT_REL && (cnt != CW'(REL_LIMIT)))  cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    timeout     = 1'b0;
    rel_timeout = 1'b0;
    proto_err   = 1'b0;
    case (state)
      IDLE:  proto_err = ack & ~req_rise;
      WAIT: begin
        timeout   = req & ~ack & (cnt == CW'(TIMEOUT));
        proto_err = ~req & ~ack & ~ABANDON_OK;
      end
      ACKED: proto_err = req & ~ack;
      REL:   rel_timeout = ack & (STRICT_REL | (cnt == CW'(REL_LIMIT)));
      default: ;
    endcase
  end

endmodule

// File: rtl/wav_dfi_hs_monitor.sv
// DFI handshake monitor: four channel trackers plus bus-idle rules,
// folded into sticky flags, a first-error index and a saturating count.
module wav_dfi_hs_monitor
  import wav_dfi_hs_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int ADDR_W       = 14,
  parameter int TLP_RESP     = 8,
  parameter int TLP_REL      = 8,
  parameter int TPHYUPD_RESP = 16,
  parameter int TCTRLUPD_MAX = 32,
  parameter int CNT_W        = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         lp_ctrl_req,
  input  logic                         lp_ctrl_ack,
  input  logic                         lp_data_req,
  input  logic                         lp_data_ack,
  input  logic                         phyupd_req,
  input  logic                         phyupd_ack,
  input  logic                         ctrlupd_req,
  input  logic                         ctrlupd_ack,
  input  logic                         phymstr_ack,
  input  logic                         init_start,
  input  logic [NUM_PHASES*ADDR_W-1:0] address,
  input  logic [NUM_PHASES-1:0]        wrdata_en,
  input  logic [NUM_PHASES-1:0]        rddata_en,
  output logic [N_ERR-1:0]             err_vec,
  output logic [3:0]                   err_first,
  output logic [CNT_W-1:0]             err_count,
  output logic [3:0]                   ch_busy
);

  logic [3:0]       to, rto, perr;
  logic             addr_cmd;
  logic [N_ERR-1:0] viol;
  logic             any_viol;

  // Low-power channels may abandon a request; update channels must release promptly.
  wav_dfi_hs_channel #(.TIMEOUT(TLP_RESP), .REL_LIMIT(TLP_REL), .ABANDON_OK(1'b1), .STRICT_REL(1'b0))
    u_lp_ctrl (.clock, .reset, .req(lp_ctrl_req), .ack(lp_ctrl_ack),
               .timeout(to[0]), .rel_timeout(rto[0]), .proto_err(perr[0]), .busy(ch_busy[0]));
  wav_dfi_hs_channel #(.TIMEOUT(TLP_RESP), .REL_LIMIT(TLP_REL), .ABANDON_OK(1'b1), .STRICT_REL(1'b0))
    u_lp_data (.clock, .reset, .req(lp_data_req), .ack(lp_data_ack),
               .timeout(to[1]), .rel_timeout(rto[1]), .proto_err(perr[1]), .busy(ch_busy[1]));
  wav_dfi_hs_channel #(.TIMEOUT(TPHYUPD_RESP), .REL_LIMIT(1), .ABANDON_OK(1'b0), .STRICT_REL(1'b1))
    u_phyupd (.clock, .reset, .req(phyupd_req), .ack(phyupd_ack),
              .timeout(to[2]), .rel_timeout(rto[2]), .proto_err(perr[2]), .busy(ch_busy[2]));
  wav_dfi_hs_channel #(.TIMEOUT(TCTRLUPD_MAX), .REL_LIMIT(1), .ABANDON_OK(1'b0), .STRICT_REL(1'b1))
    u_ctrlupd (.clock, .reset, .req(ctrlupd_req), .ack(ctrlupd_ack),
               .timeout(to[3]), .rel_timeout(rto[3]), .proto_err(perr[3]), .busy(ch_busy[3]));

  always_comb begin
    addr_cmd = 1'b0;
    for (int p = 0; p < NUM_PHASES; p++)
      if (address[p*ADDR_W +: ADDR_W] == ADDR_W'(NONIDLE_ADDR)) addr_cmd = 1'b1;
  end

  always_comb begin
    viol                  = '0;
    viol[ERR_TO_LP_CTRL]  = to[0];
    viol[ERR_TO_LP_DATA]  = to[1];
    viol[ERR_TO_PHYUPD]   = to[2];
    viol[ERR_TO_CTRLUPD]  = to[3];
    viol[ERR_REL_TIMEOUT] = |rto;
    viol[ERR_PROTO]       = |perr;
    viol[ERR_UPD_MSTR]    = phyupd_ack & phymstr_ack;
    viol[ERR_INIT]        = init_start & (ctrlupd_req | lp_ctrl_req | lp_data_req |
                                          phyupd_ack | phymstr_ack);
    viol[ERR_ADDR_BUSY]   = (phyupd_ack | ctrlupd_ack | lp_ctrl_req) & addr_cmd;
    viol[ERR_LP_DATA_EN]  = lp_data_req & (|(wrdata_en | rddata_en));
  end

  assign any_viol = |viol;

  // A violation in the clr cycle survives the clear; err_first restarts from it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_vec   <= '0;
      err_first <= '0;
      err_count <= '0;
    end else if (clr) begin
      err_vec   <= viol;
      err_first <= any_viol ? lowest_set(viol) : 4'd0;
      err_count <= any_viol ? CNT_W'(1) : '0;
    end else begin
      err_vec <= err_vec | viol;
      if (any_viol && (err_vec == '0)) err_first <= lowest_set(viol);
      if (any_viol && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wav_dfi_hs_monitor.sv
// Directed bench for wav_dfi_hs_monitor with hand-computed expectations.
// Inputs change 1ns after posedge; outputs are checked 1ns after the edge that sampled them.
module tb_wav_dfi_hs_monitor;

  localparam int NP = 4;
  localparam int AW = 14;

  logic            clock = 1'b0;
  logic            reset;
  logic            clr;
  logic            lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack;
  logic            phyupd_req, phyupd_ack, ctrlupd_req, ctrlupd_ack;
  logic            phymstr_ack, init_start;
  logic [NP*AW-1:0] address;
  logic [NP-1:0]   wrdata_en, rddata_en;
  logic [9:0]      err_vec;
  logic [3:0]      err_first;
  logic [7:0]      err_count;
  logic [3:0]      ch_busy;

  int n_tests = 0;
  int n_fail  = 0;

  wav_dfi_hs_monitor #(
    .NUM_PHASES(NP), .ADDR_W(AW), .TLP_RESP(8), .TLP_REL(8),
    .TPHYUPD_RESP(16), .TCTRLUPD_MAX(32), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .clr(clr),
    .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_ack(lp_ctrl_ack),
    .lp_data_req(lp_data_req), .lp_data_ack(lp_data_ack),
    .phyupd_req(phyupd_req), .phyupd_ack(phyupd_ack),
    .ctrlupd_req(ctrlupd_req), .ctrlupd_ack(ctrlupd_ack),
    .phymstr_ack(phymstr_ack), .init_start(init_start),
    .address(address), .wrdata_en(wrdata_en), .rddata_en(rddata_en),
    .err_vec(err_vec), .err_first(err_first), .err_count(err_count), .ch_busy(ch_busy)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] ev, input logic [3:0] ef,
                            input logic [7:0] ec, input logic [3:0] cb);
    check({tag, ".err_vec"},   32'(err_vec),   32'(ev));
    check({tag, ".err_first"}, 32'(err_first), 32'(ef));
    check({tag, ".err_count"}, 32'(err_count), 32'(ec));
    check({tag, ".ch_busy"},   32'(ch_busy),   32'(cb));
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0;
    lp_ctrl_req = 0; lp_ctrl_ack = 0; lp_data_req = 0; lp_data_ack = 0;
    phyupd_req = 0; phyupd_ack = 0; ctrlupd_req = 0; ctrlupd_ack = 0;
    phymstr_ack = 0; init_start = 0;
    address = '0; wrdata_en = '0; rddata_en = '0;

    tick(2);
    check_outs("reset", 10'h000, 4'd0, 8'd0, 4'b0000);
    reset = 1'b1;
    tick();

    // 1: clean lp_ctrl handshake
    lp_ctrl_req = 1; tick();
    check("t1.busy_wait", 32'(ch_busy), 32'h1);
    tick(2);
    lp_ctrl_ack = 1; tick(2);
    lp_ctrl_req = 0; tick(2);
    lp_ctrl_ack = 0; tick();
    check_outs("t1.done", 10'h000, 4'd0, 8'd0, 4'b0000);

    // 2: lp_data timeout fires on the 9th waiting cycle, not the 8th
    lp_data_req = 1; tick();
    tick(8);
    check("t2.no_timeout_yet", 32'(err_vec), 32'h000);
    tick();
    check_outs("t2.timeout", 10'h002, 4'd1, 8'd1, 4'b0010);
    tick(2);
    check("t2.count_runs", 32'(err_count), 32'd3);
    lp_data_req = 0; tick();
    check_outs("t2.abandon_ok", 10'h002, 4'd1, 8'd3, 4'b0000);

    // 3: phyupd timeout, then ack overlapping phymstr_ack
    clr = 1; phyupd_req = 1; tick();
    clr = 0;
    check_outs("t3.cleared", 10'h000, 4'd0, 8'd0, 4'b0100);
    tick(16);
    check("t3.no_timeout_yet", 32'(err_vec), 32'h000);
    tick();
    check_outs("t3.timeout", 10'h004, 4'd2, 8'd1, 4'b0100);
    phyupd_ack = 1; phymstr_ack = 1; tick();
    check_outs("t3.mstr", 10'h044, 4'd2, 8'd2, 4'b0100);
    phymstr_ack = 0; phyupd_req = 0; tick();
    phyupd_ack = 0; tick();
    check_outs("t3.released", 10'h044, 4'd2, 8'd2, 4'b0000);

    // 4: acks without requests while a command address is on phase 2
    clr = 1; tick();
    clr = 0;
    address[2*AW +: AW] = 14'h1;
    ctrlupd_ack = 1; phyupd_ack = 1; tick();
    check_outs("t4.addr_proto", 10'h120, 4'd5, 8'd1, 4'b0000);
    ctrlupd_ack = 0; phyupd_ack = 0; address = '0; tick();
    check_outs("t4.hold", 10'h120, 4'd5, 8'd1, 4'b0000);

    // 4b: strict release on ctrlupd, ack lingers one cycle too long
    clr = 1; ctrlupd_req = 1; ctrlupd_ack = 1; tick();
    clr = 0;
    check_outs("t4b.acked", 10'h000, 4'd0, 8'd0, 4'b1000);
    ctrlupd_req = 0; tick();
    tick();
    check_outs("t4b.rel_timeout", 10'h010, 4'd4, 8'd1, 4'b1000);
    ctrlupd_ack = 0; tick();
    check("t4b.idle", 32'(ch_busy), 32'h0);

    // 5: saturate err_count, then clr together with a fresh violation
    clr = 1; init_start = 1; phymstr_ack = 1; tick();
    clr = 0;
    check_outs("t5.clr_new", 10'h080, 4'd7, 8'd1, 4'b0000);
    tick(253);
    check("t5.count254", 32'(err_count), 32'd254);
    tick();
    check("t5.count255", 32'(err_count), 32'd255);
    tick(3);
    check("t5.saturated", 32'(err_count), 32'd255);
    init_start = 0; phymstr_ack = 0;
    clr = 1; lp_data_req = 1; wrdata_en = 4'b0100; tick();
    clr = 0;
    check_outs("t5.clr_with_viol", 10'h200, 4'd9, 8'd1, 4'b0010);
    lp_data_req = 0; wrdata_en = '0; tick();
    check_outs("t5.quiet", 10'h200, 4'd9, 8'd1, 4'b0000);

    // 6: async reset while phyupd sits in ACKED, then a clean handshake
    phyupd_req = 1; phyupd_ack = 1; tick();
    check_outs("t6.acked", 10'h200, 4'd9, 8'd1, 4'b0100);
    #2 reset = 1'b0;
    #1;
    check_outs("t6.async_reset", 10'h000, 4'd0, 8'd0, 4'b0000);
    phyupd_req = 0; phyupd_ack = 0;
    tick();
    reset = 1'b1;
    tick();
    ctrlupd_req = 1; tick(2);
    check("t6.busy_ctrlupd", 32'(ch_busy), 32'h8);
    ctrlupd_ack = 1; tick();
    ctrlupd_req = 0; tick();
    ctrlupd_ack = 0; tick();
    check_outs("t6.clean", 10'h000, 4'd0, 8'd0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
